// File: rtl/read_sector_scheduler.sv
// Per-sector fetch controller: launches a buffer read lead_cycles ahead
// of each sector and streams the returned bytes out with tid/tlast.
//
// Ports:
//   csr_aclk, csr_areset     clock, async active-high reset
//   enable, abort            launch gate, in-flight cancel pulse
//   sectors_per_track,
//   sector_bytes,
//   lead_cycles,
//   buffer_base,
//   sector_stride            geometry and timing configuration
//   sector_number,
//   cycle_count              rotational position
//   mem_req/addr/len/ack     read request handshake
//   mem_t*                   returned byte stream
//   parallel_t*              output byte stream to the read datapath
//   busy, launched_count,
//   skipped_count            status
module read_sector_scheduler #(
  parameter int ADDR_W = 32
) (
  input  logic              csr_aclk,
  input  logic              csr_areset,
  input  logic              enable,
  input  logic              abort,
  input  logic [7:0]        sectors_per_track,
  input  logic [15:0]       sector_bytes,
  input  logic [31:0]       lead_cycles,
  input  logic [ADDR_W-1:0] buffer_base,
  input  logic [15:0]       sector_stride,
  input  logic [7:0]        sector_number,
  input  logic [31:0]       cycle_count,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_len,
  input  logic              mem_ack,
  input  logic              mem_tvalid,
  output logic              mem_tready,
  input  logic [7:0]        mem_tdata,
  output logic              parallel_tvalid,
  input  logic              parallel_tready,
  output logic [7:0]        parallel_tdata,
  output logic              parallel_tlast,
  output logic [7:0]        parallel_tid,
  output logic              busy,
  output logic [15:0]       launched_count,
  output logic [15:0]       skipped_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM
  } state_t;

  state_t state, state_nxt;

  logic        cc_eq;
  logic        cc_eq_q;
  logic        trig;
  logic        id_ok;
  logic        bytes_ok;
  logic        launch;
  logic        skip;
  logic        mem_hs;
  logic        last_beat;
  logic [7:0]  id_q;
  logic [15:0] cnt_q;
  logic [23:0] prod;

  // Edge-qualified so a stalled cycle_count fires only once.
  assign cc_eq    = (cycle_count == lead_cycles);
  assign trig     = cc_eq && !cc_eq_q && !abort;
  assign id_ok    = (sector_number < sectors_per_track);
  assign bytes_ok = (sector_bytes != 16'd0);
  assign launch   = trig && enable && id_ok
                  && bytes_ok && (state == IDLE);
  assign skip     = trig && enable && bytes_ok
                  && ((state != IDLE) || !id_ok);

  assign prod = 24'(sector_number) * 24'(sector_stride);

  assign mem_req    = (state == REQ);
  assign busy       = (state != IDLE);
  assign mem_tready = (state == STREAM)
                    && (!parallel_tvalid || parallel_tready);
  assign mem_hs     = mem_tvalid && mem_tready;
  assign last_beat  = mem_hs && (cnt_q == 16'd1);

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (launch)    state_nxt = REQ;
        REQ:     if (mem_ack)   state_nxt = STREAM;
        STREAM:  if (last_beat) state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      cc_eq_q         <= 1'b0;
      id_q            <= '0;
      cnt_q           <= '0;
      mem_addr        <= '0;
      mem_len         <= '0;
      launched_count  <= '0;
      skipped_count   <= '0;
      parallel_tvalid <= 1'b0;
      parallel_tdata  <= '0;
      parallel_tlast  <= 1'b0;
      parallel_tid    <= '0;
    end else begin
      cc_eq_q <= cc_eq;
      if (launch) begin
        id_q           <= sector_number;
        mem_addr       <= buffer_base + ADDR_W'(prod);
        mem_len        <= sector_bytes;
        cnt_q          <= sector_bytes;
        launched_count <= launched_count + 16'd1;
      end
      if (skip) begin
        skipped_count <= skipped_count + 16'd1;
      end
      if (abort) begin
        cnt_q           <= '0;
        parallel_tvalid <= 1'b0;
      end else if (mem_hs) begin
        parallel_tvalid <= 1'b1;
        parallel_tdata  <= mem_tdata;
        parallel_tid    <= id_q;
        parallel_tlast  <= (cnt_q == 16'd1);
        cnt_q           <= cnt_q - 16'd1;
      end else if (parallel_tready) begin
        parallel_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_read_sector_scheduler.sv
// Directed testbench for read_sector_scheduler.
// Scenario tasks with inline hand-computed checks.
module tb_read_sector_scheduler;

  logic        csr_aclk = 1'b0;
  logic        csr_areset;
  logic        enable;
  logic        abort;
  logic [7:0]  sectors_per_track;
  logic [15:0] sector_bytes;
  logic [31:0] lead_cycles;
  logic [31:0] buffer_base;
  logic [15:0] sector_stride;
  logic [7:0]  sector_number;
  logic [31:0] cycle_count;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [15:0] mem_len;
  logic        mem_ack;
  logic        mem_tvalid;
  logic        mem_tready;
  logic [7:0]  mem_tdata;
  logic        parallel_tvalid;
  logic        parallel_tready;
  logic [7:0]  parallel_tdata;
  logic        parallel_tlast;
  logic [7:0]  parallel_tid;
  logic        busy;
  logic [15:0] launched_count;
  logic [15:0] skipped_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit tmo     = 0;
  int stall_err;
  int throttle_err;
  logic [7:0] got_d[$];
  logic [7:0] got_id[$];
  logic       got_l[$];

  read_sector_scheduler #(.ADDR_W(32)) dut (
    .csr_aclk          (csr_aclk),
    .csr_areset        (csr_areset),
    .enable            (enable),
    .abort             (abort),
    .sectors_per_track (sectors_per_track),
    .sector_bytes      (sector_bytes),
    .lead_cycles       (lead_cycles),
    .buffer_base       (buffer_base),
    .sector_stride     (sector_stride),
    .sector_number     (sector_number),
    .cycle_count       (cycle_count),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_len           (mem_len),
    .mem_ack           (mem_ack),
    .mem_tvalid        (mem_tvalid),
    .mem_tready        (mem_tready),
    .mem_tdata         (mem_tdata),
    .parallel_tvalid   (parallel_tvalid),
    .parallel_tready   (parallel_tready),
    .parallel_tdata    (parallel_tdata),
    .parallel_tlast    (parallel_tlast),
    .parallel_tid      (parallel_tid),
    .busy              (busy),
    .launched_count    (launched_count),
    .skipped_count     (skipped_count)
  );

  always #5 csr_aclk = ~csr_aclk;

  task automatic tick;
    @(posedge csr_aclk);
    #1;
  endtask

  task automatic trigger(input logic [7:0] sec);
    cycle_count = 32'd51;
    tick;
    sector_number = sec;
    cycle_count = 32'd50;
    tick;
    cycle_count = 32'd49;
  endtask

  task automatic do_ack;
    int i;
    i = 0;
    while (!mem_req && i < 20) begin
      tick;
      i++;
    end
    if (!mem_req) tmo = 1;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
  endtask

  task automatic stream(input logic [7:0] b0, input int n,
                        input bit toggle);
    int k;
    int cyc;
    bit rdy;
    bit hold_v;
    bit hs_m;
    logic [7:0] hold_d;
    k = 0;
    cyc = 0;
    rdy = 1'b1;
    hold_v = 1'b0;
    hold_d = '0;
    got_d.delete();
    got_id.delete();
    got_l.delete();
    stall_err = 0;
    throttle_err = 0;
    while (got_d.size() < n && cyc < 200) begin
      mem_tvalid = (k < n);
      mem_tdata = 8'(b0 + k);
      parallel_tready = toggle ? rdy : 1'b1;
      #1;
      if (hold_v && (!parallel_tvalid
          || parallel_tdata !== hold_d)) stall_err++;
      if (mem_tready && parallel_tvalid
          && !parallel_tready) throttle_err++;
      hs_m = mem_tvalid && mem_tready;
      if (parallel_tvalid && parallel_tready) begin
        got_d.push_back(parallel_tdata);
        got_id.push_back(parallel_tid);
        got_l.push_back(parallel_tlast);
      end
      hold_v = parallel_tvalid && !parallel_tready;
      hold_d = parallel_tdata;
      tick;
      if (hs_m) k++;
      rdy = !rdy;
      cyc++;
    end
    mem_tvalid = 1'b0;
    parallel_tready = 1'b1;
    if (cyc >= 200) tmo = 1;
  endtask

  task automatic check_bytes(input string nm, input logic [7:0] b0,
                             input logic [7:0] sec);
    n_tests++;
    if (got_d.size() !== 4) begin
      n_fail++;
      $display("FAIL %s_count got %0d exp 4", nm, got_d.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_d[i] !== 8'(b0 + i) || got_id[i] !== sec
          || got_l[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL %s_byte%0d got d=%h id=%0d l=%b exp d=%h id=%0d l=%b",
                 nm, i, got_d[i], got_id[i], got_l[i],
                 8'(b0 + i), sec, (i == 3));
      end
    end
  endtask

  task automatic test_reset;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || parallel_tvalid !== 1'b0
        || mem_addr !== 32'h0 || mem_len !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outs got req=%b busy=%b pv=%b a=%h l=%h exp zeros",
               mem_req, busy, parallel_tvalid, mem_addr, mem_len);
    end
    n_tests++;
    if (launched_count !== 16'd0 || skipped_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0",
               launched_count, skipped_count);
    end
  endtask

  task automatic test_basic;
    trigger(8'd3);
    n_tests++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h1660
        || mem_len !== 16'd4) begin
      n_fail++;
      $display("FAIL basic_req got req=%b busy=%b a=%h l=%0d exp 1 1 1660 4",
               mem_req, busy, mem_addr, mem_len);
    end
    do_ack;
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_req_drop got %b exp 0", mem_req);
    end
    stream(8'hA1, 4, 1'b0);
    check_bytes("basic", 8'hA1, 8'd3);
    n_tests++;
    if (launched_count !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end got launched=%0d busy=%b exp 1 0",
               launched_count, busy);
    end
  endtask

  task automatic test_stall;
    trigger(8'd3);
    do_ack;
    stream(8'hA1, 4, 1'b1);
    check_bytes("stall", 8'hA1, 8'd3);
    n_tests++;
    if (stall_err !== 0 || throttle_err !== 0) begin
      n_fail++;
      $display("FAIL stall_stable got stall=%0d throttle=%0d exp 0 0",
               stall_err, throttle_err);
    end
  endtask

  task automatic test_skip_busy;
    trigger(8'd3);
    do_ack;
    trigger(8'd4);
    n_tests++;
    if (mem_req !== 1'b0 || skipped_count !== 16'd1
        || launched_count !== 16'd3) begin
      n_fail++;
      $display("FAIL skip_busy got req=%b skip=%0d launch=%0d exp 0 1 3",
               mem_req, skipped_count, launched_count);
    end
    stream(8'hB1, 4, 1'b0);
    check_bytes("skip_busy", 8'hB1, 8'd3);
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_after got req=%b busy=%b exp 0 0", mem_req, busy);
    end
  endtask

  task automatic test_invalid;
    cycle_count = 32'd51;
    tick;
    sector_number = 8'd17;
    cycle_count = 32'd50;
    tick;
    tick;
    tick;
    cycle_count = 32'd49;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || skipped_count !== 16'd2) begin
      n_fail++;
      $display("FAIL invalid_id got req=%b busy=%b skip=%0d exp 0 0 2",
               mem_req, busy, skipped_count);
    end
    enable = 1'b0;
    trigger(8'd2);
    enable = 1'b1;
    n_tests++;
    if (mem_req !== 1'b0 || skipped_count !== 16'd2
        || launched_count !== 16'd3) begin
      n_fail++;
      $display("FAIL disabled got req=%b skip=%0d launch=%0d exp 0 2 3",
               mem_req, skipped_count, launched_count);
    end
    sector_bytes = 16'd0;
    trigger(8'd2);
    sector_bytes = 16'd4;
    n_tests++;
    if (mem_req !== 1'b0 || skipped_count !== 16'd2
        || launched_count !== 16'd3) begin
      n_fail++;
      $display("FAIL zero_bytes got req=%b skip=%0d launch=%0d exp 0 2 3",
               mem_req, skipped_count, launched_count);
    end
  endtask

  task automatic test_abort;
    trigger(8'd5);
    n_tests++;
    if (mem_addr !== 32'h1AA0) begin
      n_fail++;
      $display("FAIL abort_addr5 got %h exp 1aa0", mem_addr);
    end
    do_ack;
    parallel_tready = 1'b1;
    mem_tvalid = 1'b1;
    mem_tdata = 8'hD1;
    tick;
    mem_tdata = 8'hD2;
    tick;
    mem_tdata = 8'hD3;
    tick;
    mem_tvalid = 1'b0;
    parallel_tready = 1'b0;
    n_tests++;
    if (parallel_tvalid !== 1'b1 || parallel_tdata !== 8'hD3) begin
      n_fail++;
      $display("FAIL abort_pending got v=%b d=%h exp 1 d3",
               parallel_tvalid, parallel_tdata);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    parallel_tready = 1'b1;
    n_tests++;
    if (parallel_tvalid !== 1'b0 || busy !== 1'b0 || mem_tready !== 1'b0
        || launched_count !== 16'd4) begin
      n_fail++;
      $display("FAIL abort_state got v=%b busy=%b rdy=%b launch=%0d exp 0 0 0 4",
               parallel_tvalid, busy, mem_tready, launched_count);
    end
    trigger(8'd6);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1CC0 || mem_len !== 16'd4
        || launched_count !== 16'd5) begin
      n_fail++;
      $display("FAIL abort_next got req=%b a=%h l=%0d launch=%0d exp 1 1cc0 4 5",
               mem_req, mem_addr, mem_len, launched_count);
    end
    do_ack;
    stream(8'hC1, 4, 1'b0);
    check_bytes("abort_next", 8'hC1, 8'd6);
  endtask

  task automatic test_async_reset;
    trigger(8'd1);
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre got req=%b exp 1", mem_req);
    end
    csr_areset = 1'b1;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || launched_count !== 16'd0
        || skipped_count !== 16'd0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_now got req=%b busy=%b l=%0d s=%0d a=%h exp zeros",
               mem_req, busy, launched_count, skipped_count, mem_addr);
    end
    tick;
    csr_areset = 1'b0;
    tick;
    trigger(8'd2);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1440
        || launched_count !== 16'd1) begin
      n_fail++;
      $display("FAIL areset_relaunch got req=%b a=%h l=%0d exp 1 1440 1",
               mem_req, mem_addr, launched_count);
    end
    do_ack;
    stream(8'hE1, 4, 1'b0);
    check_bytes("areset_stream", 8'hE1, 8'd2);
  endtask

  initial begin
    csr_areset        = 1'b1;
    enable            = 1'b1;
    abort             = 1'b0;
    sectors_per_track = 8'd17;
    sector_bytes      = 16'd4;
    lead_cycles       = 32'd50;
    buffer_base       = 32'h1000;
    sector_stride     = 16'h0220;
    sector_number     = 8'd0;
    cycle_count       = 32'd100;
    mem_ack           = 1'b0;
    mem_tvalid        = 1'b0;
    mem_tdata         = 8'h00;
    parallel_tready   = 1'b1;
    tick;
    tick;
    csr_areset = 1'b0;
    tick;
    test_reset;
    test_basic;
    test_stall;
    test_skip_busy;
    test_invalid;
    test_abort;
    test_async_reset;
    n_tests++;
    if (tmo) begin
      n_fail++;
      $display("FAIL timeout got expired exp none");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_sector_scheduler.md
# read_sector_scheduler

Per-sector fetch controller that feeds the read datapath's parallel byte stream. It watches the rotational position (`sector_number`, `cycle_count` counting down to sector start) and launches a buffer-memory read for the upcoming sector `lead_cycles` before it arrives. It streams the returned bytes as AXI-stream with `tid` = sector number and `tlast` on the final byte. It sits between the track-buffer memory reader and the read datapath's `parallel_*` input.

## Interface
Parameters:
- `ADDR_W`, 32, buffer byte-address width.

Ports:
- `csr_aclk` in 1: sole clock.
- `csr_areset` in 1: reset; asynchronous, active-high.
- `enable` in 1: scheduling allowed; 0 stops new launches only.
- `abort` in 1: synchronous pulse; cancels any in-flight sector.
- `sectors_per_track` in 8: valid ids are 0..N-1.
- `sector_bytes` in 16: bytes streamed per sector; 0 means no stream.
- `lead_cycles` in 32: launch point in `cycle_count` units.
- `buffer_base` in ADDR_W: track buffer base byte address.
- `sector_stride` in 16: byte distance between sectors in the buffer.
- `sector_number` in 8: sector currently approaching.
- `cycle_count` in 32: cycles until that sector starts.
- `mem_req` out 1: read request.
- `mem_addr` out ADDR_W: read start address.
- `mem_len` out 16: read length in bytes.
- `mem_ack` in 1: request accepted.
- `mem_tvalid` in 1, `mem_tready` out 1, `mem_tdata` in 8: returned bytes.
- `parallel_tvalid` out 1, `parallel_tready` in 1, `parallel_tdata` out 8, `parallel_tlast` out 1, `parallel_tid` out 8: output stream.
- `busy` out 1: FSM not IDLE.
- `launched_count` out 16: sectors launched.
- `skipped_count` out 16: trigger events not launched (busy or invalid id).

## Operation
- Trigger: `cycle_count == lead_cycles` this cycle and `cycle_count` was not equal to `lead_cycles` in the previous cycle (edge-qualified, so a stalled count yields one trigger).
- FSM states IDLE, REQ, STREAM.
- IDLE → REQ on trigger when `enable` is 1, `sector_number < sectors_per_track`, and `sector_bytes != 0`. On this transition:
  - latch `id = sector_number`;
  - `mem_addr = buffer_base + id*sector_stride`: 24-bit product, zero-extended, sum truncated to ADDR_W;
  - `mem_len = sector_bytes`; byte counter = `sector_bytes`;
  - `launched_count` increments.
- Trigger while `enable` is 1 but not launched (state not IDLE, or invalid id): `skipped_count` increments, no other effect. Trigger while `enable` is 0: no count. `sector_bytes == 0`: no launch, no count.
- REQ: `mem_req` is 1 and `mem_addr`/`mem_len` are held stable until the cycle `mem_ack` is 1. Then go to STREAM.
- STREAM:
  - `mem_tready = !parallel_tvalid || parallel_tready`.
  - Each mem beat loads the output register: `tdata = mem_tdata`, `tid = id`, `tlast = (counter == 1)`. The counter decrements.
  - When the beat with counter==1 is accepted from mem, go to IDLE. The output register may still hold that last byte; IDLE does not clear it.
  - Extra mem beats after the sector ends are not accepted: `mem_tready` is 0 outside STREAM.
- Output register: `parallel_tvalid` rises on a load and falls on `parallel_tready` with no simultaneous load. Data is stable while valid and not ready.
- `abort`, in any state: FSM → IDLE, `mem_req` → 0, `parallel_tvalid` → 0, byte counter cleared. Counters are unchanged. A trigger in the same cycle as abort is ignored and not counted.
- `enable` falling mid-sector does not stop the current sector.
- Counters wrap at 16 bits.
- Reset values: state IDLE; all outputs 0, including `mem_addr`, `mem_len`, `parallel_*`, `busy`, and both counters.

## Timing
- Trigger cycle T: `mem_req` and `busy` are 1 from T+1.
- `mem_ack` at cycle A: `mem_req` is 0 at A+1; the first `mem_tready` is possible at A+1.
- Beat accepted from mem at cycle B: `parallel_tvalid`/data appear at B+1. Latency is 1 cycle.
- Full throughput is one byte per cycle with `parallel_tready` held at 1.
- Back-to-back sectors: a trigger is launchable in the cycle after STREAM returns to IDLE.
- `busy` is 0 the cycle after the last mem beat is accepted.

## Test plan
- Base 0x1000, stride 0x220, `sector_bytes`=4, `lead_cycles`=50, `sector_number`=3, `cycle_count` counting down through 50 → `mem_addr`=0x1660 and `mem_len`=4. After ack, mem bytes 0xA1..0xA4 → out bytes 0xA1..0xA4, tid 3, tlast only on 0xA4. `launched_count`=1.
- Same run with `parallel_tready` toggling 1/0 each cycle → no byte lost or duplicated, data stable while stalled, `mem_tready` throttled accordingly.
- Second trigger (sector 4) while STREAM of sector 3 is in progress → sector 3 completes intact, no request for sector 4, `skipped_count`=1.
- `sector_number`=17 with `sectors_per_track`=17 at trigger → no `mem_req`, `skipped_count`=1. `enable`=0 at trigger → no request, both counters 0.
- `abort` after 2 of 4 bytes are delivered, with a byte pending in the output register → `parallel_tvalid`=0 and IDLE next cycle. The next trigger starts a fresh sector at its own address with the full count.
- Assert `csr_areset` mid-REQ with no clock edge → `mem_req`, `busy`, and counters read 0 immediately. After release, a trigger at `cycle_count`==`lead_cycles` launches normally.
